wrr_arbiter: RTL

Weighted round-robin arbiter that shares one val/rdy output stream among `ninputs` val/rdy sources, granting each source a burst of up to its configured weight in beats before rotating. It sits in the arbiter_router datapath in front of the router or any shared consumer. It tags every output beat with the source index, in the same `{index, msg}` format the existing arbiter produces. Unlike the existing arbiter, which holds a grant indefinitely, this block bounds starvation with per-grant beat quotas.

---
 rtl/arbiter_pkg.sv | 12 +
 rtl/rr_priority_picker.sv | 32 +++
 rtl/wrr_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/arbiter_pkg.sv
// Shared types for the arbiter_router datapath arbiters.
// Holds the WRR arbiter FSM states and the width of its optional statistics counters.
package arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } wrr_state_e;

    localparam int STAT_NBITS = 16;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating priority encoder.
// Returns the first asserted request found by scanning upward from ptr, wrapping at ninputs-1.
module rr_priority_picker #(
    parameter  int ninputs    = 3,
    localparam int addr_nbits = $clog2(ninputs)
) (
    input  logic [ninputs-1:0]    req,
    input  logic [addr_nbits-1:0] ptr,
    output logic                  any,
    output logic [addr_nbits-1:0] sel
);

    int idx;

    // Scan from the far end so the candidate closest to ptr is written last and wins.
    always_comb begin
        any = 1'b0;
        sel = '0;
        idx = 0;
        for (int k = ninputs - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= ninputs) begin
                idx = idx - ninputs;
            end
            if (req[idx]) begin
                any = 1'b1;
                sel = addr_nbits'(idx);
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: grants each source a burst of up to its weight in beats.
// Optional per-source transfer counters are built when WRR_ARBITER_STATS_EN is defined.
module wrr_arbiter
    import arbiter_pkg::*;
#(
    parameter  int nbits      = 32,
    parameter  int ninputs    = 3,
    parameter  int max_weight = 4,
    localparam int addr_nbits = $clog2(ninputs),
    localparam int wbits      = $clog2(max_weight + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ninputs-1:0]            istream_val,
    output logic [ninputs-1:0]            istream_rdy,
    input  logic [nbits-1:0]              istream_msg [ninputs],
    output logic                          ostream_val,
    input  logic                          ostream_rdy,
    output logic [addr_nbits+nbits-1:0]   ostream_msg,
    input  logic [wbits-1:0]              cfg_weight  [ninputs],
`ifdef WRR_ARBITER_STATS_EN
    input  logic                          stat_clr,
    output logic [STAT_NBITS-1:0]         stat_xfers  [ninputs],
`endif
    output wrr_state_e                    dbg_state
);

    // Handshake: a beat moves on a cycle where val && rdy; a source holds msg while val && !rdy.

    wrr_state_e            state_q,  state_d;
    logic [addr_nbits-1:0] grant_q,  grant_d;
    logic [wbits-1:0]      count_q,  count_d;
    logic [addr_nbits-1:0] rr_ptr_q, rr_ptr_d;

    logic                  pick_any;
    logic [addr_nbits-1:0] pick_sel;
    logic [wbits-1:0]      w_eff;

    function automatic logic [wbits-1:0] eff_weight(input logic [wbits-1:0] w);
        if (w == '0) begin
            return wbits'(1);
        end
        if (w > wbits'(max_weight)) begin
            return wbits'(max_weight);
        end
        return w;
    endfunction

    function automatic logic [addr_nbits-1:0] next_idx(input logic [addr_nbits-1:0] i);
        return (i == addr_nbits'(ninputs - 1)) ? '0 : i + addr_nbits'(1);
    endfunction

    rr_priority_picker #(.ninputs(ninputs)) u_picker (
        .req (istream_val),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .sel (pick_sel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Outputs are gated by reset so they drop without waiting for a clock edge.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        count_d     = count_q;
        rr_ptr_d    = rr_ptr_q;
        ostream_val = 1'b0;
        istream_rdy = '0;
        ostream_msg = '0;
        w_eff       = eff_weight(cfg_weight[pick_sel]);
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        ostream_val           = 1'b1;
                        istream_rdy[pick_sel] = ostream_rdy;
                        ostream_msg           = {pick_sel, istream_msg[pick_sel]};
                        if (ostream_rdy && (w_eff == wbits'(1))) begin
                            rr_ptr_d = next_idx(pick_sel);
                        end else begin
                            state_d = GRANT;
                            grant_d = pick_sel;
                            count_d = ostream_rdy ? (w_eff - wbits'(1)) : w_eff;
                        end
                    end
                end
                GRANT: begin
                    ostream_val          = istream_val[grant_q];
                    istream_rdy[grant_q] = ostream_rdy;
                    ostream_msg          = {grant_q, istream_msg[grant_q]};
                    if (!istream_val[grant_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_idx(grant_q);
                    end else if (ostream_rdy) begin
                        if (count_q == wbits'(1)) begin
                            state_d  = IDLE;
                            rr_ptr_d = next_idx(grant_q);
                        end else begin
                            count_d = count_q - wbits'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state_q;

`ifdef WRR_ARBITER_STATS_EN
    logic [STAT_NBITS-1:0] stat_q [ninputs];

    // Clear takes priority; counters saturate at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ninputs; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ninputs; i++) begin
                if (stat_clr) begin
                    stat_q[i] <= '0;
                end else if (istream_val[i] && istream_rdy[i] && (stat_q[i] != '1)) begin
                    stat_q[i] <= stat_q[i] + STAT_NBITS'(1);
                end
            end
        end
    end

    assign stat_xfers = stat_q;
`endif

endmodule
